// File: rtl/ipe_viol_ctrl.sv
// IPE/bootcode violation collector: sticky flags, first-fault address, saturating
// event counter and NMI/PUC request sequencing behind a 4-word register window.
module ipe_viol_ctrl #(
   parameter logic [14:0]       BASE_ADDR   = 15'h05B0,
   parameter int                DEC_WD      = 3,
   parameter logic [DEC_WD-1:0] STAT_OFFSET = 'h0,
   parameter logic [DEC_WD-1:0] ADDR_OFFSET = 'h2,
   parameter logic [DEC_WD-1:0] CNT_OFFSET  = 'h4,
   parameter logic [DEC_WD-1:0] CTL_OFFSET  = 'h6
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout,
   input  logic        ipe_fe_violation,
   input  logic        ipe_eu_violation,
   input  logic        ipe_dma_violation,
   input  logic        ipe_dbg_mem_violation,
   input  logic        bootcode_fe_violation,
   input  logic        bootcode_eu_violation,
   input  logic        bootcode_dma_violation,
   input  logic        bootcode_dbg_violation,
   input  logic [15:0] fe_pc_nxt,
   input  logic [15:0] eu_mab,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dbg_mem_addr,
   input  logic        nmi_acc,
   output logic        viol_nmi_req,
   output logic        viol_puc_req,
   output logic        viol_pending
);

   typedef enum logic [1:0] {IDLE, PEND, ACK, PUC} state_t;
   state_t state_reg, state_next;

   logic [8:0]        stat_reg, stat_next;
   logic [15:0]       addr_reg, addr_next;
   logic [15:0]       cnt_reg, cnt_next;
   logic              nmi_en_reg, puc_en_reg, lock_reg;
   logic              viol_any_dly_reg;

   logic              reg_sel, reg_wr, reg_rd;
   logic [DEC_WD-1:0] reg_off;
   logic              wr_stat, wr_cnt, wr_ctl;
   logic [7:0]        viol_vec;
   logic              viol_any;
   logic              unused_din;

   assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
   assign reg_off = {per_addr[DEC_WD-2:0], 1'b0};
   assign reg_wr  = reg_sel & (|per_we);
   assign reg_rd  = reg_sel & ~(|per_we);
   assign wr_stat = reg_wr & (reg_off == STAT_OFFSET);
   assign wr_cnt  = reg_wr & (reg_off == CNT_OFFSET);
   assign wr_ctl  = reg_wr & (reg_off == CTL_OFFSET);
   assign unused_din = &{1'b0, per_din[15:9]};

   assign viol_vec = {bootcode_dbg_violation, bootcode_dma_violation,
                      bootcode_eu_violation,  bootcode_fe_violation,
                      ipe_dbg_mem_violation,  ipe_dma_violation,
                      ipe_eu_violation,       ipe_fe_violation};
   assign viol_any = |viol_vec;

   // A new strobe always beats a simultaneous write-1-to-clear of the same flag
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_flag
         assign stat_next[gi] = viol_vec[gi] | (stat_reg[gi] & ~(wr_stat & per_din[gi]));
      end
   endgenerate
   assign stat_next[8] = (viol_any & (|stat_reg[7:0])) |
                         (stat_reg[8] & ~(wr_stat & per_din[8]));

   always_comb begin
      addr_next = addr_reg;
      if (viol_any && (stat_reg[7:0] == 8'h00)) begin
         if (viol_vec[0] | viol_vec[4])      addr_next = fe_pc_nxt;
         else if (viol_vec[1] | viol_vec[5]) addr_next = eu_mab;
         else if (viol_vec[2] | viol_vec[6]) addr_next = dma_addr;
         else                                addr_next = dbg_mem_addr;
      end
   end

   always_comb begin
      cnt_next = cnt_reg;
      if (wr_cnt)
         cnt_next = 16'h0000;
      else if (viol_any && !viol_any_dly_reg && (cnt_reg != 16'hFFFF))
         cnt_next = cnt_reg + 16'd1;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (viol_any && puc_en_reg)      state_next = PUC;
            else if (viol_any && nmi_en_reg) state_next = PEND;
         end
         PEND:    if (nmi_acc) state_next = ACK;
         ACK:     state_next = viol_any ? PEND : IDLE;
         PUC:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state_reg        <= IDLE;
         stat_reg         <= '0;
         addr_reg         <= '0;
         cnt_reg          <= '0;
         nmi_en_reg       <= 1'b0;
         puc_en_reg       <= 1'b0;
         lock_reg         <= 1'b0;
         viol_any_dly_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         stat_reg         <= stat_next;
         addr_reg         <= addr_next;
         cnt_reg          <= cnt_next;
         viol_any_dly_reg <= viol_any;
         if (wr_ctl && !lock_reg) begin
            nmi_en_reg <= per_din[0];
            puc_en_reg <= per_din[1];
            lock_reg   <= per_din[7];
         end
      end
   end

   assign viol_nmi_req = (state_reg == PEND);
   assign viol_puc_req = (state_reg == PUC);
   assign viol_pending = |stat_reg;

   always_comb begin
      per_dout = 16'h0000;
      if (reg_rd) begin
         case (reg_off)
            STAT_OFFSET: per_dout = {7'd0, stat_reg};
            ADDR_OFFSET: per_dout = addr_reg;
            CNT_OFFSET:  per_dout = cnt_reg;
            CTL_OFFSET:  per_dout = {8'd0, lock_reg, 5'd0, puc_en_reg, nmi_en_reg};
            default:     per_dout = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_ipe_viol_ctrl.sv
// Directed + randomized bench for ipe_viol_ctrl against a behavioural model of
// the violation flags, capture, counter and request sequencing.
module tb_ipe_viol_ctrl;
   localparam logic [13:0] W_STAT = 14'h02D8;
   localparam logic [13:0] W_ADDR = 14'h02D9;
   localparam logic [13:0] W_CNT  = 14'h02DA;
   localparam logic [13:0] W_CTL  = 14'h02DB;

   logic        mclk = 1'b0;
   logic        puc_rst = 1'b1;
   logic [13:0] per_addr = '0;
   logic [15:0] per_din = '0;
   logic        per_en = 1'b0;
   logic [1:0]  per_we = '0;
   logic [15:0] per_dout;
   logic        ipe_fe_violation = 0, ipe_eu_violation = 0, ipe_dma_violation = 0, ipe_dbg_mem_violation = 0;
   logic        bootcode_fe_violation = 0, bootcode_eu_violation = 0, bootcode_dma_violation = 0, bootcode_dbg_violation = 0;
   logic [15:0] fe_pc_nxt = '0, eu_mab = '0, dma_addr = '0, dbg_mem_addr = '0;
   logic        nmi_acc = 1'b0;
   logic        viol_nmi_req, viol_puc_req, viol_pending;

   int errors = 0;
   int checks = 0;

   // model state: m_phase 0=no request, 1=NMI waiting, 2=acknowledge gap, 3=PUC pulse
   logic [8:0]  m_stat;
   logic [15:0] m_addr, m_cnt;
   logic        m_nmi_en, m_puc_en, m_lock, m_prev_any;
   int          m_phase;

   ipe_viol_ctrl dut (
      .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
      .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
      .ipe_fe_violation(ipe_fe_violation), .ipe_eu_violation(ipe_eu_violation),
      .ipe_dma_violation(ipe_dma_violation), .ipe_dbg_mem_violation(ipe_dbg_mem_violation),
      .bootcode_fe_violation(bootcode_fe_violation), .bootcode_eu_violation(bootcode_eu_violation),
      .bootcode_dma_violation(bootcode_dma_violation), .bootcode_dbg_violation(bootcode_dbg_violation),
      .fe_pc_nxt(fe_pc_nxt), .eu_mab(eu_mab), .dma_addr(dma_addr), .dbg_mem_addr(dbg_mem_addr),
      .nmi_acc(nmi_acc), .viol_nmi_req(viol_nmi_req), .viol_puc_req(viol_puc_req),
      .viol_pending(viol_pending)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_viol(input logic [7:0] v);
      {bootcode_dbg_violation, bootcode_dma_violation, bootcode_eu_violation, bootcode_fe_violation,
       ipe_dbg_mem_violation, ipe_dma_violation, ipe_eu_violation, ipe_fe_violation} = v;
   endtask

   task automatic model_reset();
      m_stat = '0; m_addr = '0; m_cnt = '0;
      m_nmi_en = 0; m_puc_en = 0; m_lock = 0; m_prev_any = 0; m_phase = 0;
   endtask

   task automatic model_edge();
      logic [7:0] v;
      bit any, wr, ovf;
      int off;
      v = {bootcode_dbg_violation, bootcode_dma_violation, bootcode_eu_violation, bootcode_fe_violation,
           ipe_dbg_mem_violation, ipe_dma_violation, ipe_eu_violation, ipe_fe_violation};
      any = (v != 0);
      wr  = per_en && (per_we != 0) && (per_addr >= W_STAT) && (per_addr <= W_CTL);
      off = int'(per_addr) - int'(W_STAT);
      case (m_phase)
         0: if (any && m_puc_en) m_phase = 3; else if (any && m_nmi_en) m_phase = 1;
         1: if (nmi_acc) m_phase = 2;
         2: m_phase = any ? 1 : 0;
         default: m_phase = 0;
      endcase
      ovf = any && (m_stat[7:0] != 0);
      if (any && m_stat[7:0] == 0)
         m_addr = (v[0] || v[4]) ? fe_pc_nxt : (v[1] || v[5]) ? eu_mab :
                  (v[2] || v[6]) ? dma_addr : dbg_mem_addr;
      if (wr && off == 0) m_stat = m_stat & ~per_din[8:0];
      m_stat = m_stat | {ovf, v};
      if (wr && off == 2) m_cnt = 0;
      else if (any && !m_prev_any && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      m_prev_any = any;
      if (wr && off == 3 && !m_lock) begin
         m_nmi_en = per_din[0]; m_puc_en = per_din[1]; m_lock = per_din[7];
      end
   endtask

   task automatic check_outputs();
      chk("nmi_req", {15'd0, viol_nmi_req}, {15'd0, m_phase == 1});
      chk("puc_req", {15'd0, viol_puc_req}, {15'd0, m_phase == 3});
      chk("pending", {15'd0, viol_pending}, {15'd0, m_stat != 0});
      chk("dout_idle", per_dout, 16'h0000);
   endtask

   task automatic cycle();
      @(posedge mclk);
      if (puc_rst) model_reset(); else model_edge();
      #1;
      check_outputs();
   endtask

   task automatic read_regs();
      per_en = 1; per_we = 0;
      per_addr = W_STAT; #1 chk("STAT", per_dout, {7'd0, m_stat});
      per_addr = W_ADDR; #1 chk("ADDR", per_dout, m_addr);
      per_addr = W_CNT;  #1 chk("CNT", per_dout, m_cnt);
      per_addr = W_CTL;  #1 chk("CTL", per_dout, {8'd0, m_lock, 5'd0, m_puc_en, m_nmi_en});
      per_addr = W_CTL + 14'd1; #1 chk("outside", per_dout, 16'h0000);
      per_en = 0;
   endtask

   task automatic wr_reg(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
      per_en = 1; per_we = we; per_addr = a; per_din = d;
      cycle();
      $display("write addr=%h data=%h we=%0d", a, d, we);
      per_en = 0; per_we = 0;
   endtask

   task automatic pulse(input logic [7:0] v);
      set_viol(v);
      cycle();
      set_viol(8'h00);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge mclk);
      #1;
      check_outputs();
      read_regs();
      puc_rst = 0;
      cycle();

      // basic NMI flow
      wr_reg(W_CTL, 16'h0001, 2'b11);
      eu_mab = 16'h8010;
      pulse(8'h02);
      read_regs();
      cycle(); cycle();
      nmi_acc = 1; cycle(); nmi_acc = 0;
      cycle();
      wr_reg(W_STAT, 16'h0002, 2'b01);
      read_regs();

      // capture priority and overflow
      fe_pc_nxt = 16'h8020; dma_addr = 16'h1000; dbg_mem_addr = 16'h2222;
      pulse(8'h41);
      read_regs();
      pulse(8'h08);
      read_regs();
      nmi_acc = 1; cycle(); nmi_acc = 0;
      cycle();
      wr_reg(W_STAT, 16'h01FF, 2'b11);
      wr_reg(W_CNT, 16'h0000, 2'b10);
      wr_reg(W_CTL, 16'h0000, 2'b11);

      // counter: one long assertion plus two pulses, then saturation
      set_viol(8'h04);
      repeat (5) cycle();
      set_viol(8'h00);
      cycle();
      pulse(8'h10); cycle();
      pulse(8'h80); cycle();
      read_regs();
      force dut.cnt_reg = 16'hFFFE;
      m_cnt = 16'hFFFE;
      cycle();
      release dut.cnt_reg;
      pulse(8'h01); cycle();
      pulse(8'h01); cycle();
      read_regs();
      wr_reg(W_CNT, 16'h1234, 2'b11);
      read_regs();
      set_viol(8'h04);
      wr_reg(W_CNT, 16'h0000, 2'b11);
      set_viol(8'h00);
      read_regs();
      wr_reg(W_STAT, 16'h01FF, 2'b11);

      // acknowledge coinciding with a fresh violation
      wr_reg(W_CTL, 16'h0001, 2'b11);
      pulse(8'h01);
      cycle();
      nmi_acc = 1; set_viol(8'h01); cycle();
      nmi_acc = 0; cycle();
      set_viol(8'h00); cycle();
      nmi_acc = 1; cycle(); nmi_acc = 0;
      cycle();

      // nmi_en dropped while pending does not retract the request
      pulse(8'h20);
      wr_reg(W_CTL, 16'h0000, 2'b11);
      cycle(); cycle();
      nmi_acc = 1; cycle(); nmi_acc = 0;
      cycle();
      wr_reg(W_STAT, 16'h01FF, 2'b11);

      // set beats clear on the same bit
      set_viol(8'h01);
      wr_reg(W_STAT, 16'h0001, 2'b11);
      set_viol(8'h00);
      read_regs();
      wr_reg(W_STAT, 16'h01FF, 2'b11);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] v;
         v = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
         set_viol(v);
         fe_pc_nxt = 16'($urandom); eu_mab = 16'($urandom);
         dma_addr = 16'($urandom); dbg_mem_addr = 16'($urandom);
         nmi_acc = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) begin
            logic [13:0] a;
            logic [15:0] d;
            a = W_STAT + 14'($urandom_range(0, 3));
            d = 16'($urandom);
            if (a == W_CTL) d = d & 16'h0003;
            wr_reg(a, d, 2'($urandom_range(1, 3)));
         end else begin
            cycle();
         end
         if (i % 8 == 7) read_regs();
      end
      set_viol(8'h00); nmi_acc = 0;
      cycle(); cycle();

      // asynchronous reset while an NMI is pending
      wr_reg(W_CTL, 16'h0001, 2'b11);
      wr_reg(W_STAT, 16'h01FF, 2'b11);
      nmi_acc = 0;
      pulse(8'h01);
      while (m_phase != 1) begin
         nmi_acc = 0; cycle();
         if (checks > 20000) begin
            chk("pend_timeout", 16'h0001, 16'h0000);
            break;
         end
      end
      #2 puc_rst = 1;
      model_reset();
      #1;
      check_outputs();
      read_regs();
      cycle();
      puc_rst = 0;

      // locked control with PUC priority
      wr_reg(W_CTL, 16'h0083, 2'b11);
      pulse(8'h10);
      cycle();
      wr_reg(W_CTL, 16'h0000, 2'b11);
      read_regs();

      // asynchronous reset during the PUC pulse clears the lock
      pulse(8'h01);
      #1 puc_rst = 1;
      model_reset();
      #1;
      check_outputs();
      cycle();
      puc_rst = 0;
      read_regs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ipe_viol_ctrl.md
# ipe_viol_ctrl

Violation collector and NMI/PUC request generator sitting directly downstream of the IPE/bootcode protection peripheral. It consumes the eight per-cycle violation strobes (IPE fetch/EU/DMA/debug, bootcode fetch/EU/DMA/debug) and latches them into sticky status flags. It also captures the first faulting address, keeps a saturating event count, and drives a level NMI request held until the core acknowledges it, or a one-cycle PUC request when configured. Software reads and clears everything through a 16-bit peripheral register window.

## Interface
Parameters:
- BASE_ADDR, 15'h05B0, register window base, aligned to DEC_WD.
- DEC_WD, 3, address decode width (4 word registers).
- STAT_OFFSET, 'h0, VIOL_STAT: sticky flags, write-1-to-clear.
- ADDR_OFFSET, 'h2, VIOL_ADDR: first faulting address, read-only.
- CNT_OFFSET, 'h4, VIOL_CNT: saturating event counter; any write clears it.
- CTL_OFFSET, 'h6, VIOL_CTL: bit0 nmi_en, bit1 puc_en, bit7 lock.

Ports:
- mclk  in  1  main clock.
- puc_rst  in  1  reset, asynchronous, active-high.
- per_addr  in  14  peripheral word address.
- per_din  in  16  write data.
- per_en  in  1  peripheral access enable.
- per_we  in  2  byte write enables; any nonzero value is a full word write.
- per_dout  out  16  read data; 0 when not selected.
- ipe_fe_violation, ipe_eu_violation, ipe_dma_violation, ipe_dbg_mem_violation  in  1 each  IPE violation strobes.
- bootcode_fe_violation, bootcode_eu_violation, bootcode_dma_violation, bootcode_dbg_violation  in  1 each  bootcode violation strobes.
- fe_pc_nxt, eu_mab, dma_addr, dbg_mem_addr  in  16 each  addresses used for capture.
- nmi_acc  in  1  NMI accepted by the frontend.
- viol_nmi_req  out  1  level NMI request.
- viol_puc_req  out  1  one-cycle PUC request pulse.
- viol_pending  out  1  OR of VIOL_STAT[8:0].

## Operation
- VIOL_STAT bits:
  - [0] ipe_fe, [1] ipe_eu, [2] ipe_dma, [3] ipe_dbg.
  - [4] boot_fe, [5] boot_eu, [6] boot_dma, [7] boot_dbg.
  - [8] overflow: a violation arrived while [7:0] was already nonzero.
  - [15:9] read 0.
- Flag set and write-1-to-clear on the same bit in the same cycle: set wins.
- VIOL_ADDR loads only when VIOL_STAT[7:0]==0 and a violation is present. Source by priority:
  - fe (either) → fe_pc_nxt
  - eu (either) → eu_mab
  - dma (either) → dma_addr
  - dbg (either) → dbg_mem_addr
- VIOL_ADDR otherwise holds until reset. Clearing STAT re-arms capture.
- viol_any = OR of the 8 strobes. VIOL_CNT increments on each rising edge of viol_any (registered previous value) and saturates at 16'hFFFF. A write clears it; write and increment in the same cycle → 0.
- VIOL_CTL: with lock=1, further CTL writes are ignored until puc_rst. STAT and CNT remain writable.
- FSM states:
  - IDLE: on viol_any with puc_en=1 → PUC (puc_en has priority over nmi_en). On viol_any with nmi_en=1 → PEND. Otherwise stay.
  - PEND: viol_nmi_req=1; on nmi_acc → ACK.
  - ACK: one cycle. If viol_any → PEND, else → IDLE.
  - PUC: viol_puc_req=1 for exactly one cycle → IDLE.
- With both enables 0, only flags, address and counter update; the FSM stays in IDLE.
- nmi_en cleared while in PEND: the request stays up until nmi_acc (no retraction).

## Timing
- All outputs are registered except per_dout, which is combinational on per_en/per_addr/per_we (read when per_we==0).
- Violation strobe at cycle N:
  - STAT/ADDR/CNT visible from cycle N+1.
  - viol_nmi_req or viol_puc_req high from cycle N+1.
  - viol_pending high from N+1.
- nmi_acc at cycle M while in PEND: viol_nmi_req low at M+1 (ACK). It re-asserts at M+2 only if viol_any was high at M+1.
- Register write at cycle K takes effect at K+1. A read at K returns the pre-write value.
- Reset values: all registers 0, FSM IDLE, viol_nmi_req=0, viol_puc_req=0, viol_pending=0, per_dout=0.
- puc_rst asserted mid-PEND or mid-PUC: immediate return to IDLE with outputs low, lock cleared.

## Test plan
- CTL=0x0001; pulse ipe_eu_violation 1 cycle with eu_mab=0x8010 → next cycle STAT=0x0002, ADDR=0x8010, CNT=1, viol_nmi_req=1. Hold until nmi_acc, low the cycle after; write STAT=0x0002 → STAT=0, viol_pending=0.
- Same cycle ipe_fe_violation (fe_pc_nxt=0x8020) and bootcode_dma_violation (dma_addr=0x1000) → STAT=0x0041, ADDR=0x8020. Then ipe_dbg_mem_violation → STAT=0x0149, ADDR unchanged.
- viol_any held high 5 cycles, then 2 pulses → CNT=3. Preload via 0xFFFF rising edges (or force) → CNT stays 0xFFFF; write CNT → 0.
- CTL=0x0083 (lock, nmi_en, puc_en); boot_fe violation → viol_puc_req high exactly 1 cycle, viol_nmi_req stays 0. Write CTL=0 → reads back 0x0083.
- In PEND, nmi_acc coincides with a new ipe_fe_violation (viol_any high during ACK) → nmi_req low 1 cycle, then high again.
- Write STAT=0x0001 in the same cycle ipe_fe_violation=1 → STAT[0] remains 1. Assert puc_rst while nmi_req=1 → all outputs 0 asynchronously.
